// File: rtl/systolic_mm_engine.sv
// systolic_mm_engine
// Output-stationary N x N systolic matrix-multiply engine. Each beat supplies
// one A column (a_vec) and one B row (b_vec). The engine skews them on chip,
// accumulates C = A*B in the PE array, and exposes C through a registered
// indexed read port.
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous active-high reset
//   start     begin a job (sampled only while idle)
//   k_len     number of vector pairs in the job, latched on start
//   in_valid  a_vec/b_vec valid
//   in_ready  engine accepts a vector pair this cycle
//   a_vec     A[i][k] in bits [i*DATA_W +: DATA_W]
//   b_vec     B[k][j] in bits [j*DATA_W +: DATA_W]
//   busy      a job is in progress, held through the done pulse
//   done      one-cycle pulse, all C[i][j] final
//   rd_idx    result index i*N+j; indices >= N*N read as 0
//   rd_data   registered C[rd_idx]
module systolic_mm_engine #(
    parameter int unsigned N      = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 24,
    parameter int unsigned KW     = 8,
    parameter int unsigned SIGNED = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [KW-1:0]                 k_len,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N*DATA_W-1:0]           a_vec,
    input  logic [N*DATA_W-1:0]           b_vec,
    output logic                          busy,
    output logic                          done,
    input  logic [$clog2(N*N+1)-1:0]      rd_idx,
    output logic [ACC_W-1:0]              rd_data
);

    // Index port is one value wider than N*N-1 needs so out-of-range reads exist.
    localparam int unsigned IDX_W     = $clog2(N*N+1);
    localparam int unsigned ACC_DEPTH = 1 << IDX_W;
    // Product width: wide enough for the full product and for the accumulator.
    localparam int unsigned PW        = (ACC_W > 2*DATA_W) ? ACC_W : 2*DATA_W;
    localparam int unsigned DRAIN_W   = $clog2(2*N);
    localparam int unsigned CNT_W     = (KW > DRAIN_W) ? KW : DRAIN_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_in_ready;
    logic               r_busy;
    logic               r_done;
    logic               w_in_ready_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic [KW-1:0]      r_klen;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_accept;
    logic               w_clr;
    logic [ACC_W-1:0]   r_rd_data;

    logic [DATA_W-1:0]  w_a_edge [N];
    logic [DATA_W-1:0]  w_b_edge [N];
    logic [DATA_W-1:0]  w_a_op   [N][N];
    logic [DATA_W-1:0]  w_b_op   [N][N];
    logic [ACC_W-1:0]   w_acc    [ACC_DEPTH];

    assign in_ready = r_in_ready;
    assign busy     = r_busy;
    assign done     = r_done;
    assign rd_data  = r_rd_data;

    // in_ready is registered from the next state, so it equals (state == LOAD).
    assign w_accept  = in_valid & r_in_ready;
    assign w_clr     = (r_state == S_IDLE) & start;
    assign w_cnt_inc = r_cnt + CNT_W'(1);

    // Sign- or zero-extend an operand to the product width.
    function automatic logic [PW-1:0] ext_op(input logic [DATA_W-1:0] v);
        logic [PW-1:0] r;
        r = '0;
        r[DATA_W-1:0] = v;
        for (int b = DATA_W; b < PW; b++) begin
            r[b] = (SIGNED != 0) & v[DATA_W-1];
        end
        return r;
    endfunction

    // State and registered control outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= w_in_ready_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (k_len == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_accept && (w_cnt_inc == CNT_W'(r_klen))) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Last beat reaches PE(N-1,N-1) 2N-1 edges after acceptance.
                if (r_cnt == CNT_W'(2*N-2)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode; done lags DONE by one cycle so rd_data is final with it.
    always_comb begin
        w_in_ready_nxt = 1'b0;
        w_busy_nxt     = 1'b0;
        w_done_nxt     = 1'b0;
        w_in_ready_nxt = (w_state_nxt == S_LOAD);
        w_busy_nxt     = (w_state_nxt != S_IDLE) | (r_state == S_DONE);
        w_done_nxt     = (r_state == S_DONE);
    end

    // Beat / drain counter, restarted on every state change.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_state_nxt != r_state) begin
            r_cnt <= '0;
        end else if (((r_state == S_LOAD) && w_accept) || (r_state == S_DRAIN)) begin
            r_cnt <= w_cnt_inc;
        end
    end

    // Job length captured at start.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_klen <= '0;
        end else if (w_clr) begin
            r_klen <= k_len;
        end
    end

    // Input skew: row/column g passes through g+1 registers; bubbles inject 0.
    for (genvar g = 0; g < N; g++) begin : g_skew
        logic [DATA_W-1:0] r_a_sk [g+1];
        logic [DATA_W-1:0] r_b_sk [g+1];

        always_ff @(posedge clk) begin
            if (reset || w_clr) begin
                for (int d = 0; d <= g; d++) begin
                    r_a_sk[d] <= '0;
                    r_b_sk[d] <= '0;
                end
            end else begin
                r_a_sk[0] <= w_accept ? a_vec[g*DATA_W +: DATA_W] : '0;
                r_b_sk[0] <= w_accept ? b_vec[g*DATA_W +: DATA_W] : '0;
                for (int d = 1; d <= g; d++) begin
                    r_a_sk[d] <= r_a_sk[d-1];
                    r_b_sk[d] <= r_b_sk[d-1];
                end
            end
        end

        assign w_a_edge[g] = r_a_sk[g];
        assign w_b_edge[g] = r_b_sk[g];
    end

    // PE array: A flows right, B flows down, C stays in place.
    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic [ACC_W-1:0] r_acc;
            logic [PW-1:0]    w_prod;

            if (j == 0) begin : g_a_edge
                assign w_a_op[i][0] = w_a_edge[i];
            end
            if (i == 0) begin : g_b_edge
                assign w_b_op[0][j] = w_b_edge[j];
            end

            assign w_prod = ext_op(w_a_op[i][j]) * ext_op(w_b_op[i][j]);

            always_ff @(posedge clk) begin
                if (reset || w_clr) begin
                    r_acc <= '0;
                end else begin
                    r_acc <= r_acc + w_prod[ACC_W-1:0];
                end
            end

            assign w_acc[i*N+j] = r_acc;

            if (j < N-1) begin : g_pass_a
                logic [DATA_W-1:0] r_a;
                always_ff @(posedge clk) begin
                    if (reset || w_clr) begin
                        r_a <= '0;
                    end else begin
                        r_a <= w_a_op[i][j];
                    end
                end
                assign w_a_op[i][j+1] = r_a;
            end

            if (i < N-1) begin : g_pass_b
                logic [DATA_W-1:0] r_b;
                always_ff @(posedge clk) begin
                    if (reset || w_clr) begin
                        r_b <= '0;
                    end else begin
                        r_b <= w_b_op[i][j];
                    end
                end
                assign w_b_op[i+1][j] = r_b;
            end
        end
    end

    // Unpopulated read indices return zero.
    for (genvar e = N*N; e < ACC_DEPTH; e++) begin : g_acc_pad
        assign w_acc[e] = '0;
    end

    // Registered result read port.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_acc[rd_idx];
        end
    end

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Directed bench for systolic_mm_engine: three instances (unsigned/24-bit,
// signed/24-bit, unsigned/16-bit) share one stimulus stream.
module tb_systolic_mm_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  k_len;
    logic        in_valid;
    logic [31:0] a_vec;
    logic [31:0] b_vec;
    logic [4:0]  rd_idx;

    logic        in_ready_u, busy_u, done_u;
    logic        in_ready_s, busy_s, done_s;
    logic        in_ready_w, busy_w, done_w;
    logic [23:0] rd_u;
    logic [23:0] rd_s;
    logic [15:0] rd_w;

    logic [7:0]  ma [4][4];   // A[i][k]
    logic [7:0]  mb [4][4];   // B[k][j]

    int n_checks = 0;
    int n_fail   = 0;
    int dcyc;

    always #5 clk = ~clk;

    systolic_mm_engine #(.N(4), .DATA_W(8), .ACC_W(24), .KW(8), .SIGNED(0)) u_dut (
        .clk(clk), .reset(reset), .start(start), .k_len(k_len), .in_valid(in_valid),
        .in_ready(in_ready_u), .a_vec(a_vec), .b_vec(b_vec), .busy(busy_u),
        .done(done_u), .rd_idx(rd_idx), .rd_data(rd_u));

    systolic_mm_engine #(.N(4), .DATA_W(8), .ACC_W(24), .KW(8), .SIGNED(1)) u_dut_s (
        .clk(clk), .reset(reset), .start(start), .k_len(k_len), .in_valid(in_valid),
        .in_ready(in_ready_s), .a_vec(a_vec), .b_vec(b_vec), .busy(busy_s),
        .done(done_s), .rd_idx(rd_idx), .rd_data(rd_s));

    systolic_mm_engine #(.N(4), .DATA_W(8), .ACC_W(16), .KW(8), .SIGNED(0)) u_dut_w (
        .clk(clk), .reset(reset), .start(start), .k_len(k_len), .in_valid(in_valid),
        .in_ready(in_ready_w), .a_vec(a_vec), .b_vec(b_vec), .busy(busy_w),
        .done(done_w), .rd_idx(rd_idx), .rd_data(rd_w));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_identity();
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                ma[i][k] = (i == k) ? 8'd1 : 8'd0;
                mb[i][k] = 8'(4*i + k + 1);
            end
    endtask

    task automatic set_const(input logic [7:0] av, input logic [7:0] bv);
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                ma[i][k] = av;
                mb[i][k] = bv;
            end
    endtask

    task automatic drive_beat(input int k);
        for (int i = 0; i < 4; i++) begin
            a_vec[i*8 +: 8] = ma[i][k % 4];
            b_vec[i*8 +: 8] = mb[k % 4][i];
        end
    endtask

    // Runs one job; returns the number of edges after the start edge at which
    // done was first seen (-1 on timeout). Returns in the done cycle.
    task automatic run_job(input int kk, input int stall_pct, input int restart_cyc,
                           output int done_cyc);
        int cyc;
        int beats;
        bit acc;
        bit got_done;
        start = 1'b1;
        k_len = 8'(kk);
        in_valid = 1'b0;
        tick();
        start = 1'b0;
        k_len = 8'hA5;
        check_eq("busy_rise", 32'(busy_u), 32'd1);
        cyc = 0;
        beats = 0;
        got_done = 1'b0;
        done_cyc = -1;
        while (!got_done && cyc < 2000) begin
            start = (cyc == restart_cyc);
            if (cyc == restart_cyc) k_len = 8'd1;
            if (beats < kk && int'($urandom_range(99)) >= stall_pct) begin
                in_valid = 1'b1;
                drive_beat(beats);
            end else begin
                in_valid = 1'b0;
                a_vec = '1;
                b_vec = '1;
            end
            acc = in_valid && in_ready_u;
            tick();
            cyc++;
            if (acc) begin
                beats++;
                if (beats == kk) check_eq("in_ready_drain", 32'(in_ready_u), 32'd0);
            end
            if (done_u) begin
                got_done = 1'b1;
                done_cyc = cyc;
                check_eq("done_all", {30'd0, done_s, done_w}, 32'd3);
            end
        end
        start = 1'b0;
        in_valid = 1'b0;
        if (!got_done) check_eq("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_pulse_end();
        check_eq("in_ready_done", 32'(in_ready_u), 32'd0);
        tick();
        check_eq("done_pulse", 32'(done_u), 32'd0);
        check_eq("busy_fall", 32'(busy_u), 32'd0);
    endtask

    task automatic read_idx(input int idx, output logic [23:0] vu,
                            output logic [23:0] vs, output logic [15:0] vw);
        rd_idx = 5'(idx);
        tick();
        vu = rd_u;
        vs = rd_s;
        vw = rd_w;
    endtask

    initial begin
        logic [23:0] vu, vs;
        logic [15:0] vw;
        int exp_c;

        reset = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0;
        a_vec = '0; b_vec = '0; rd_idx = '0;
        repeat (3) tick();
        check_eq("rst_in_ready", 32'(in_ready_u), 32'd0);
        check_eq("rst_busy", 32'(busy_u), 32'd0);
        check_eq("rst_done", 32'(done_u), 32'd0);
        check_eq("rst_rd", 32'(rd_u), 32'd0);
        reset = 1'b0;
        tick();

        // Identity A, B[k][j] = 4k+j+1, no stalls.
        set_identity();
        rd_idx = 5'd5;
        run_job(4, 0, -1, dcyc);
        check_eq("id_done_cyc", 32'(dcyc), 32'd12);
        check_eq("id_rd5_done", 32'(rd_u), 32'd6);
        check_pulse_end();
        for (int e = 0; e < 16; e++) begin
            read_idx(e, vu, vs, vw);
            check_eq($sformatf("id_c%0d", e), 32'(vu), 32'(4*(e/4) + (e%4) + 1));
        end

        // Random operands, ~40% stalls, against a matrix-product model.
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                ma[i][k] = 8'($urandom_range(255));
                mb[i][k] = 8'($urandom_range(255));
            end
        run_job(4, 40, -1, dcyc);
        check_pulse_end();
        for (int e = 0; e < 16; e++) begin
            exp_c = 0;
            for (int k = 0; k < 4; k++) exp_c += int'(ma[e/4][k]) * int'(mb[k][e%4]);
            read_idx(e, vu, vs, vw);
            check_eq($sformatf("rnd_c%0d", e), 32'(vu), 32'(exp_c) & 32'hFF_FFFF);
        end

        // All -128 operands, K=255.
        set_const(8'h80, 8'h80);
        run_job(255, 0, -1, dcyc);
        check_eq("neg_done_cyc", 32'(dcyc), 32'd263);
        check_pulse_end();
        for (int e = 0; e < 16; e++) begin
            read_idx(e, vu, vs, vw);
            check_eq($sformatf("neg_s_c%0d", e), 32'(vs), 32'd4177920);
            check_eq($sformatf("neg_u_c%0d", e), 32'(vu), 32'd4177920);
            check_eq($sformatf("neg_w_c%0d", e), 32'(vw), 32'hC000);
        end

        // -128 x 127, K=1.
        set_const(8'h80, 8'h7F);
        run_job(1, 0, -1, dcyc);
        check_eq("mix_done_cyc", 32'(dcyc), 32'd9);
        check_pulse_end();
        for (int e = 0; e < 16; e += 5) begin
            read_idx(e, vu, vs, vw);
            check_eq($sformatf("mix_s_c%0d", e), 32'(vs), 32'hFF_C080);
            check_eq($sformatf("mix_u_c%0d", e), 32'(vu), 32'h3F80);
        end

        // All 255, K=2: wraps in the 16-bit accumulator.
        set_const(8'hFF, 8'hFF);
        run_job(2, 0, -1, dcyc);
        check_pulse_end();
        for (int e = 0; e < 16; e += 3) begin
            read_idx(e, vu, vs, vw);
            check_eq($sformatf("ff_w_c%0d", e), 32'(vw), 32'd64514);
            check_eq($sformatf("ff_u_c%0d", e), 32'(vu), 32'd130050);
            check_eq($sformatf("ff_s_c%0d", e), 32'(vs), 32'd2);
        end

        // K=0: done one edge later, results cleared.
        run_job(0, 0, -1, dcyc);
        check_eq("k0_done_cyc", 32'(dcyc), 32'd1);
        check_pulse_end();
        for (int e = 0; e < 16; e += 5) begin
            read_idx(e, vu, vs, vw);
            check_eq($sformatf("k0_c%0d", e), {vu[15:0], vw}, 32'd0);
        end

        // start (with k_len=1) during busy is ignored.
        set_identity();
        run_job(4, 0, 2, dcyc);
        check_eq("rs_done_cyc", 32'(dcyc), 32'd12);
        check_pulse_end();
        for (int e = 0; e < 16; e += 5) begin
            read_idx(e, vu, vs, vw);
            check_eq($sformatf("rs_c%0d", e), 32'(vu), 32'(4*(e/4) + (e%4) + 1));
        end

        // Reset after two accepted beats.
        rd_idx = 5'd0;
        start = 1'b1; k_len = 8'd4;
        tick();
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            drive_beat(k);
            tick();
        end
        in_valid = 1'b0;
        tick();
        check_eq("pre_rst_partial", 32'(rd_u), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("mid_rst_busy", {29'd0, busy_u, busy_s, busy_w}, 32'd0);
        check_eq("mid_rst_in_ready", 32'(in_ready_u), 32'd0);
        check_eq("mid_rst_done", 32'(done_u), 32'd0);
        check_eq("mid_rst_rd", 32'(rd_u), 32'd0);
        tick();
        check_eq("mid_rst_acc", 32'(rd_u), 32'd0);
        run_job(4, 0, -1, dcyc);
        check_eq("post_rst_done_cyc", 32'(dcyc), 32'd12);
        check_pulse_end();
        for (int e = 0; e < 16; e++) begin
            read_idx(e, vu, vs, vw);
            check_eq($sformatf("post_rst_c%0d", e), 32'(vu), 32'(4*(e/4) + (e%4) + 1));
        end
        read_idx(16, vu, vs, vw);
        check_eq("rd_oob16", 32'(vu), 32'd0);
        read_idx(31, vu, vs, vw);
        check_eq("rd_oob31", 32'(vu), 32'd0);
        check_eq("in_ready_idle", {29'd0, in_ready_u, in_ready_s, in_ready_w}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
